// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the receiver),
// parity-type selectors and line levels for start/stop bits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } uart_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the latched payload and bit counter; presents the data bit that the
// FSM registers onto the line on the coming edge.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic [DATA_WIDTH-1:0] ser_word
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      cnt_nxt;

  // bit_cnt is the index currently on the line; it saturates at the last bit
  assign ser_done = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

  always_comb begin
    cnt_nxt = bit_cnt;
    if (load) begin
      cnt_nxt = '0;
    end else if (advance && !ser_done) begin
      cnt_nxt = bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      bit_cnt <= '0;
    end else begin
      if (load) begin
        data_q <= data_in;
      end
      bit_cnt <= cnt_nxt;
    end
  end

  assign ser_data = data_q[cnt_nxt];
  assign ser_word = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit.
// One bit per clk; TX_OUT and Busy are registered from next-state values.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_state_t           state;
  uart_state_t           state_nxt;
  logic                  tx_nxt;
  logic                  busy_nxt;
  logic                  load;
  logic                  advance;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit;
  logic                  ser_data;
  logic                  ser_done;
  logic [DATA_WIDTH-1:0] ser_word;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (advance),
    .data_in  (P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done),
    .ser_word (ser_word)
  );

  assign par_bit = (par_typ_q == PAR_ODD) ? ~(^ser_word) : (^ser_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      TX_OUT    <= STOP_BIT;
      Busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      Busy   <= busy_nxt;
      if (load) begin
        par_en_q  <= Par_En;
        par_typ_q <= Par_Typ;
      end
    end
  end

  // Outputs describe the state being entered, so they line up with it after the edge
  always_comb begin
    state_nxt = state;
    tx_nxt    = STOP_BIT;
    busy_nxt  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          load      = 1'b1;
          state_nxt = START;
          tx_nxt    = START_BIT;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        tx_nxt    = ser_data;
        busy_nxt  = 1'b1;
      end
      DATA: begin
        advance  = 1'b1;
        busy_nxt = 1'b1;
        if (!ser_done) begin
          tx_nxt = ser_data;
        end else if (par_en_q) begin
          state_nxt = PARITY;
          tx_nxt    = par_bit;
        end else begin
          state_nxt = STOP;
          tx_nxt    = STOP_BIT;
        end
      end
      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = STOP_BIT;
        busy_nxt  = 1'b1;
      end
      STOP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected {TX_OUT,Busy} per cycle are
// queued when a request is driven and popped as the line is sampled.
module tb_uart_tx;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_En;
  logic       Par_Typ;
  logic       TX_OUT;
  logic       Busy;

  int   assertions = 0;
  int   failures   = 0;
  exp_t sb[$];

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_En     (Par_En),
    .Par_Typ    (Par_Typ),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  // Reference frame: start, LSB-first data, parity making total ones match type, stop, one idle
  function automatic void push_frame(input logic [7:0] d, input logic pen, input logic ptyp);
    int ones;
    exp_t e;
    ones = 0;
    e.tx = 1'b0; e.busy = 1'b1; sb.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.tx = d[i]; e.busy = 1'b1; sb.push_back(e);
      if (d[i]) ones++;
    end
    if (pen) begin
      e.tx = ((ones % 2) == 1) != ptyp; e.busy = 1'b1; sb.push_back(e);
    end
    e.tx = 1'b1; e.busy = 1'b1; sb.push_back(e);
    e.tx = 1'b1; e.busy = 1'b0; sb.push_back(e);
  endfunction

  function automatic void push_idle(input int n);
    exp_t e;
    e.tx = 1'b1; e.busy = 1'b0;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0; Par_En = 1'b0; Par_Typ = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    assertions++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL reset_state: TX_OUT/Busy=%b%b expected 10", TX_OUT, Busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      assertions++;
      if ({TX_OUT, Busy} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL idle cycle %0d: TX_OUT/Busy=%b%b expected 10", i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic pen, input logic ptyp);
    exp_t e;
    int k;
    P_DATA = d; Par_En = pen; Par_Typ = ptyp; Data_Valid = 1'b1;
    push_frame(d, pen, ptyp);
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      Data_Valid = 1'b0;
      e = sb.pop_front();
      assertions++;
      if ({TX_OUT, Busy} !== e) begin
        failures++;
        $display("[TB] FAIL %s cycle %0d: TX_OUT/Busy=%b%b expected %b%b",
                 name, k, TX_OUT, Busy, e.tx, e.busy);
      end
      k++;
    end
  endtask

  task automatic test_no_parity();
    run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0);
    run_frame("a5_odd", 8'hA5, 1'b1, 1'b1);
  endtask

  // Inputs are disturbed mid-frame; the frame must be unaffected and not repeated
  task automatic test_ignore_inputs();
    exp_t e;
    int k;
    P_DATA = 8'h01; Par_En = 1'b1; Par_Typ = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h01, 1'b1, 1'b0);
    push_idle(4);
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      Data_Valid = 1'b0;
      if (k == 4) begin
        P_DATA = 8'hFF; Par_En = 1'b0; Par_Typ = 1'b1; Data_Valid = 1'b1;
      end
      e = sb.pop_front();
      assertions++;
      if ({TX_OUT, Busy} !== e) begin
        failures++;
        $display("[TB] FAIL ignore_inputs cycle %0d: TX_OUT/Busy=%b%b expected %b%b",
                 k, TX_OUT, Busy, e.tx, e.busy);
      end
      k++;
    end
    Par_Typ = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    exp_t e;
    P_DATA = 8'h3C; Par_En = 1'b0; Par_Typ = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      Data_Valid = 1'b0;
      e = sb.pop_front();
      assertions++;
      if ({TX_OUT, Busy} !== e) begin
        failures++;
        $display("[TB] FAIL pre_reset cycle %0d: TX_OUT/Busy=%b%b expected %b%b",
                 k, TX_OUT, Busy, e.tx, e.busy);
      end
    end
    rst_n = 1'b0;
    #1;
    assertions++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL async_reset: TX_OUT/Busy=%b%b expected 10", TX_OUT, Busy);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      assertions++;
      if ({TX_OUT, Busy} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL post_reset_idle cycle %0d: TX_OUT/Busy=%b%b expected 10", i, TX_OUT, Busy);
      end
    end
    run_frame("3c_after_reset", 8'h3C, 1'b0, 1'b0);
  endtask

  // Data_Valid held high: second frame starts right after a single idle cycle
  task automatic test_back_to_back();
    exp_t e;
    int k;
    P_DATA = 8'h55; Par_En = 1'b0; Par_Typ = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0);
    push_frame(8'hAA, 1'b0, 1'b0);
    push_idle(3);
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      if (k == 0) P_DATA = 8'hAA;
      if (k == 11) Data_Valid = 1'b0;
      e = sb.pop_front();
      assertions++;
      if ({TX_OUT, Busy} !== e) begin
        failures++;
        $display("[TB] FAIL back_to_back cycle %0d: TX_OUT/Busy=%b%b expected %b%b",
                 k, TX_OUT, Busy, e.tx, e.busy);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_no_parity();
    test_parity();
    test_ignore_inputs();
    test_mid_frame_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
